ir_cmd_scheduler: RTL and testbench

- Control block between ir_decoder and the command consumers.
- Latches each decoded 32-bit frame and validates the NEC complement fields, address and command.
- Tags held-button repeats, buffers accepted commands in a small first-word-fall-through (FWFT) FIFO with a valid/ready output, and counts drops.
- On any decoder error it sequences a decoder reset pulse to resynchronise the decoder.

---
 rtl/ir_cmd_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_ir_cmd_scheduler.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ir_cmd_scheduler.sv
// ir_cmd_scheduler: validates NEC frames, tags held-button repeats, queues commands, resets the decoder on error.
// Latency: new_code_in at N -> CHECK N+1 -> PUSH N+2 -> cmd_valid_out at N+3 when the FIFO was empty.
// Backpressure: cmd_ready_in pops the FWFT head; a frame meeting a full FIFO is dropped and counted.
// Optional IR_ADDR_FILTER_EN: only frames addressed to ADDR are accepted.

module ir_cmd_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_vld,
    input  logic [WIDTH-1:0] i_wr_dat,
    output logic             o_wr_rdy,
    output logic             o_rd_vld,
    output logic [WIDTH-1:0] o_rd_dat,
    input  logic             i_rd_rdy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    assign w_full   = (r_count == CW'(DEPTH));
    assign o_rd_vld = (r_count != '0);
    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign o_wr_rdy = !w_full || i_rd_rdy;
    assign w_pop    = o_rd_vld && i_rd_rdy;
    assign w_push   = i_wr_vld && o_wr_rdy;
    assign o_rd_dat = o_rd_vld ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end
endmodule

module ir_cmd_scheduler #(
    parameter logic [7:0] ADDR           = 8'h20,
    parameter int         FIFO_DEPTH     = 4,
    parameter int         HOLD_CYCLES    = 11000000,
    parameter int         RECOVER_CYCLES = 16
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] code_in,
    input  logic        new_code_in,
    input  logic [2:0]  error_in,
    output logic        dec_rst_out,
    output logic [7:0]  cmd_out,
    output logic [7:0]  addr_out,
    output logic        repeat_out,
    output logic        cmd_valid_out,
    input  logic        cmd_ready_in,
    output logic [7:0]  drop_count_out,
    output logic [1:0]  state_out
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHECK   = 2'd1,
        ST_PUSH    = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] cmd;
        logic       rpt;
    } meta_t;

    localparam int TW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = $clog2(RECOVER_CYCLES) + 1;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_code;
    logic [31:0] r_last_code;
    logic [TW-1:0] r_hold;
    logic [RW-1:0] r_rec_cnt;
    logic [7:0]  r_drop;

    logic        w_code_ok;
    logic        w_addr_ok;
    logic        w_repeat;
    logic        w_latch;
    logic        w_rec_start;
    logic        w_fifo_wr_vld;
    logic        w_fifo_wr_rdy;
    logic        w_fifo_rd_vld;
    meta_t       w_fifo_wr_dat;
    meta_t       w_fifo_rd_dat;
    logic        w_drop_busy;
    logic        w_drop_fsm;
    logic [8:0]  w_drop_sum;

    assign w_code_ok = (r_code[23:16] == ~r_code[31:24]) && (r_code[7:0] == ~r_code[15:8]);
`ifdef IR_ADDR_FILTER_EN
    assign w_addr_ok = (r_code[31:24] == ADDR);
`else
    assign w_addr_ok = (r_code[31:24] == ADDR) || 1'b1;
`endif

    // A repeat is the same full frame seen again while the hold window is still open.
    assign w_repeat      = (r_code == r_last_code) && (r_hold != '0);
    assign w_fifo_wr_dat = '{addr: r_code[31:24], cmd: r_code[15:8], rpt: w_repeat};
    assign w_drop_busy   = new_code_in && (r_state != ST_IDLE);

    always_comb begin
        w_state_nxt   = r_state;
        w_latch       = 1'b0;
        w_rec_start   = 1'b0;
        w_fifo_wr_vld = 1'b0;
        w_drop_fsm    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (error_in != 3'd0) begin
                    w_state_nxt = ST_RECOVER;
                    w_rec_start = 1'b1;
                    w_drop_fsm  = new_code_in;
                end else if (new_code_in) begin
                    w_state_nxt = ST_CHECK;
                    w_latch     = 1'b1;
                end
            end
            ST_CHECK: begin
                if (w_code_ok && w_addr_ok) begin
                    w_state_nxt = ST_PUSH;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_drop_fsm  = 1'b1;
                end
            end
            ST_PUSH: begin
                w_fifo_wr_vld = 1'b1;
                w_drop_fsm    = !w_fifo_wr_rdy;
                w_state_nxt   = ST_IDLE;
            end
            ST_RECOVER: begin
                if (r_rec_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Up to two drops can land in one cycle (internal reject plus a strobe while busy).
    assign w_drop_sum = {1'b0, r_drop} + {8'd0, w_drop_busy} + {8'd0, w_drop_fsm};

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_code      <= '0;
            r_last_code <= '0;
            r_hold      <= '0;
            r_rec_cnt   <= '0;
            r_drop      <= '0;
        end else begin
            if (w_latch) begin
                r_code <= code_in;
            end
            if (r_state == ST_PUSH) begin
                r_last_code <= r_code;
                r_hold      <= TW'(HOLD_CYCLES);
            end else if (r_hold != '0) begin
                r_hold <= r_hold - TW'(1);
            end
            if (w_rec_start) begin
                r_rec_cnt <= RW'(RECOVER_CYCLES - 1);
            end else if (r_rec_cnt != '0) begin
                r_rec_cnt <= r_rec_cnt - RW'(1);
            end
            r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    ir_cmd_fifo #(
        .WIDTH ($bits(meta_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk    (clk_in),
        .i_rst_n  (rst_n_in),
        .i_wr_vld (w_fifo_wr_vld),
        .i_wr_dat (w_fifo_wr_dat),
        .o_wr_rdy (w_fifo_wr_rdy),
        .o_rd_vld (w_fifo_rd_vld),
        .o_rd_dat (w_fifo_rd_dat),
        .i_rd_rdy (cmd_ready_in)
    );

    assign dec_rst_out    = (r_state == ST_RECOVER);
    assign state_out      = r_state;
    assign cmd_valid_out  = w_fifo_rd_vld;
    assign cmd_out        = w_fifo_rd_dat.cmd;
    assign addr_out       = w_fifo_rd_dat.addr;
    assign repeat_out     = w_fifo_rd_dat.rpt;
    assign drop_count_out = r_drop;
endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// Bench for ir_cmd_scheduler: vector table, directed corner sequences and a random run against a frame-level model.
module tb_ir_cmd_scheduler;
    localparam int DEPTH = 4;
    localparam int HOLD  = 100;
    localparam int RC    = 16;
`ifdef IR_ADDR_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] code = '0;
    logic        new_code = 1'b0;
    logic [2:0]  err = '0;
    logic        rdy = 1'b0;
    logic        dec_rst;
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic        rep;
    logic        vld;
    logic [7:0]  drop;
    logic [1:0]  st;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ir_cmd_scheduler #(
        .ADDR           (8'h20),
        .FIFO_DEPTH     (DEPTH),
        .HOLD_CYCLES    (HOLD),
        .RECOVER_CYCLES (RC)
    ) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .code_in        (code),
        .new_code_in    (new_code),
        .error_in       (err),
        .dec_rst_out    (dec_rst),
        .cmd_out        (cmd),
        .addr_out       (addr),
        .repeat_out     (rep),
        .cmd_valid_out  (vld),
        .cmd_ready_in   (rdy),
        .drop_count_out (drop),
        .state_out      (st)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (time %0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    typedef struct packed {
        logic [7:0] a;
        logic [7:0] c;
        logic       r;
    } ment_t;

    ment_t       mq[$];
    int          t, chk_t, push_t, rec_until, last_push;
    bit          have_push;
    logic [31:0] m_code, m_last;
    int          m_drop;

    function automatic bit frame_ok(input logic [31:0] c);
        return (c[23:16] == ~c[31:24]) && (c[7:0] == ~c[15:8]) && (!FILT || c[31:24] == 8'h20);
    endfunction

    // Phase of the block in cycle c, derived from when the current frame or error arrived.
    function automatic logic [1:0] m_state(input int c);
        if (c == chk_t)     return 2'd1;
        if (c == push_t)    return 2'd2;
        if (c <= rec_until) return 2'd3;
        return 2'd0;
    endfunction

    task automatic m_reset();
        mq.delete();
        t = 0; chk_t = -10; push_t = -10; rec_until = -10; last_push = -1000;
        have_push = 0; m_code = '0; m_last = '0; m_drop = 0;
    endtask

    task automatic m_step();
        logic [1:0] prev;
        int         inc;
        bit         r;
        t++;
        prev = m_state(t - 1);
        inc  = 0;
        if (mq.size() > 0 && rdy) void'(mq.pop_front());
        if (new_code && prev != 2'd0) inc++;
        case (prev)
            2'd0: begin
                if (err != 3'd0) begin
                    rec_until = t + RC - 1;
                    if (new_code) inc++;
                end else if (new_code) begin
                    chk_t  = t;
                    m_code = code;
                end
            end
            2'd1: if (frame_ok(m_code)) push_t = t; else inc++;
            2'd2: begin
                r = (m_code == m_last) && have_push && (t - 1 - last_push < HOLD);
                if (mq.size() < DEPTH) mq.push_back('{a: m_code[31:24], c: m_code[15:8], r: r});
                else inc++;
                m_last = m_code; last_push = t; have_push = 1;
            end
            default: ;
        endcase
        m_drop = (m_drop + inc > 255) ? 255 : m_drop + inc;
    endtask

    task automatic m_compare();
        ment_t       h;
        logic [1:0]  es;
        logic [28:0] act, exp;
        h   = (mq.size() > 0) ? mq[0] : '0;
        es  = m_state(t);
        act = {dec_rst, st, vld, addr, cmd, rep, drop};
        exp = {es == 2'd3, es, mq.size() > 0, h.a, h.c, h.r, 8'(m_drop)};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL model cycle %0d: got {dec,st,vld,addr,cmd,rep,drop}=%h, expected %h", t, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_reset();
        end else begin
            m_step();
            #2;
            if (rst_n) m_compare();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; new_code = 1'b0; err = '0; rdy = 1'b0; code = '0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic send(input logic [31:0] c);
        code = c; new_code = 1'b1;
        step();
        new_code = 1'b0;
        step(2);
    endtask

    task automatic pop_one();
        rdy = 1'b1;
        step();
        rdy = 1'b0;
    endtask

    typedef struct {
        logic [31:0] code;
        bit          ok;
        bit          rpt;
        logic [7:0]  e_addr;
        logic [7:0]  e_cmd;
    } vec_t;

    vec_t vt[10];

    initial begin
        int         exp_drop;
        logic [7:0] c8;

        vt[0] = '{32'h20DF10EF, 1'b1,  1'b0, 8'h20, 8'h10};
        vt[1] = '{32'hDEADBEEF, 1'b0,  1'b0, 8'h00, 8'h00};
        vt[2] = '{32'h00FF00FF, !FILT, 1'b0, 8'h00, 8'h00};
        vt[3] = '{32'h20DFFF00, 1'b1,  1'b0, 8'h20, 8'hFF};
        vt[4] = '{32'h20DFFF00, 1'b1,  1'b1, 8'h20, 8'hFF};
        vt[5] = '{32'h20DE10EF, 1'b0,  1'b0, 8'h00, 8'h00};
        vt[6] = '{32'h20DF10EE, 1'b0,  1'b0, 8'h00, 8'h00};
        vt[7] = '{32'h7F80C03F, !FILT, 1'b0, 8'h7F, 8'hC0};
        vt[8] = '{32'h20DF10EF, 1'b1,  1'b0, 8'h20, 8'h10};
        vt[9] = '{32'h20DF10EF, 1'b1,  1'b1, 8'h20, 8'h10};

        // Reset values
        step(2);
        chk("rst_vld", vld, 0);   chk("rst_cmd", cmd, 0);   chk("rst_addr", addr, 0);
        chk("rst_rep", rep, 0);   chk("rst_drop", drop, 0); chk("rst_state", st, 0);
        chk("rst_dec", dec_rst, 0);
        rst_n = 1'b1;
        step();

        // First-frame latency
        code = 32'h20DF10EF; new_code = 1'b1;
        step();
        new_code = 1'b0;
        chk("lat_n1_state", st, 1); chk("lat_n1_vld", vld, 0);
        step();
        chk("lat_n2_state", st, 2); chk("lat_n2_vld", vld, 0);
        step();
        chk("lat_n3_vld", vld, 1);  chk("lat_n3_addr", addr, 8'h20); chk("lat_n3_cmd", cmd, 8'h10);
        chk("lat_n3_rep", rep, 0);  chk("lat_n3_drop", drop, 0);     chk("lat_n3_state", st, 0);

        // Complement failures
        do_reset();
        send(32'hDEADBEEF);
        chk("cmp1_state", st, 0);
        send(32'hA5A55A5A);
        chk("cmp_drop", drop, 2); chk("cmp_vld", vld, 0); chk("cmp_state", st, 0);

        // Hold-window repeat tagging
        do_reset();
        send(32'h20DF10EF);
        step(47);
        send(32'h20DF10EF);
        chk("rep1_rep", rep, 0);
        pop_one();
        chk("rep2_vld", vld, 1); chk("rep2_rep", rep, 1);
        pop_one();
        step(145);
        send(32'h20DF10EF);
        chk("rep3_vld", vld, 1); chk("rep3_rep", rep, 0);

        // FIFO full drop, then ordered drain
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            c8 = 8'(i);
            send({8'h20, 8'hDF, c8, ~c8});
        end
        chk("full_drop", drop, 1); chk("full_vld", vld, 1);
        rdy = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            chk($sformatf("drain_vld_%0d", i), vld, 1);
            chk($sformatf("drain_cmd_%0d", i), cmd, i);
            step();
        end
        rdy = 1'b0;
        chk("drain_empty", vld, 0);

        // Error recovery with coincident and mid-recover strobes
        do_reset();
        code = 32'h20DF10EF; err = 3'd2; new_code = 1'b1;
        step();
        err = '0; new_code = 1'b0;
        for (int i = 0; i < RC; i++) begin
            chk($sformatf("rec_state_%0d", i), st, 3);
            chk($sformatf("rec_dec_%0d", i), dec_rst, 1);
            if (i == 0) chk("rec_drop_first", drop, 1);
            new_code = (i == 7);
            step();
        end
        new_code = 1'b0;
        chk("rec_end_state", st, 0); chk("rec_end_dec", dec_rst, 0);
        chk("rec_end_drop", drop, 2); chk("rec_end_vld", vld, 0);

        // Address filter frame
        do_reset();
        send(32'h04FB08F7);
        chk("filt_vld", vld, !FILT);
        chk("filt_addr", addr, FILT ? 8'h00 : 8'h04);
        chk("filt_cmd", cmd, FILT ? 8'h00 : 8'h08);
        chk("filt_drop", drop, FILT ? 1 : 0);

        // Vector table
        do_reset();
        exp_drop = 0;
        foreach (vt[i]) begin
            send(vt[i].code);
            exp_drop += vt[i].ok ? 0 : 1;
            chk($sformatf("tbl%0d_vld", i), vld, vt[i].ok);
            chk($sformatf("tbl%0d_drop", i), drop, exp_drop);
            if (vt[i].ok) begin
                chk($sformatf("tbl%0d_addr", i), addr, vt[i].e_addr);
                chk($sformatf("tbl%0d_cmd", i), cmd, vt[i].e_cmd);
                chk($sformatf("tbl%0d_rep", i), rep, vt[i].rpt);
                pop_one();
            end
        end

        // Drop counter saturation
        do_reset();
        err = 3'd1; new_code = 1'b1;
        step(300);
        err = '0; new_code = 1'b0;
        step(20);
        chk("sat_drop", drop, 255); chk("sat_state", st, 0);

        // Asynchronous reset in the middle of RECOVER with a queued entry
        send(32'h20DF10EF);
        err = 3'd4;
        step();
        err = '0;
        step(3);
        chk("arst_pre_dec", dec_rst, 1); chk("arst_pre_vld", vld, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_dec", dec_rst, 0); chk("arst_vld", vld, 0);
        chk("arst_drop", drop, 0);   chk("arst_state", st, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        // Randomized traffic checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            new_code = ($urandom_range(0, 99) < 30);
            case ($urandom_range(0, 3))
                0:       code = 32'h20DF10EF;
                1:       code = 32'h20DF40BF;
                2:       code = 32'h04FB08F7;
                default: code = $urandom;
            endcase
            err = ($urandom_range(0, 99) < 2) ? 3'($urandom_range(1, 7)) : 3'd0;
            rdy = ($urandom_range(0, 99) < (((i / 500) % 2) != 0 ? 15 : 60));
            step();
        end
        new_code = 1'b0; err = '0; rdy = 1'b0;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
